// File: rtl/rt_pkg.sv
// Shared constants for the reaction-timer engine:
// FSM state encodings and LFSR tap masks.
package rt_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Bit k-1 set for each x^k term of a maximal-length polynomial.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] m;
    case (width)
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/reaction_timer_core_if.sv
// Control pulses in, status and BCD buses out,
// between the key/switch logic and the reaction-timer core.
interface reaction_timer_core_if #(
  parameter int N_DIGITS = 4
);
  logic                    start;
  logic                    stop;
  logic                    clear;
  logic                    best_clr;
  logic                    show_best;
  logic [1:0]              state;
  logic                    go_led;
  logic                    false_start;
  logic [4*N_DIGITS-1:0]   count_bcd;
  logic [4*N_DIGITS-1:0]   best_bcd;
  logic                    best_valid;
  logic                    overflow;
  logic [4*N_DIGITS-1:0]   disp_bcd;

  modport master (
    output start, stop, clear,
    output best_clr, show_best,
    input  state, go_led, false_start,
    input  count_bcd, best_bcd,
    input  best_valid, overflow, disp_bcd
  );

  modport slave (
    input  start, stop, clear,
    input  best_clr, show_best,
    output state, go_led, false_start,
    output count_bcd, best_bcd,
    output best_valid, overflow, disp_bcd
  );
endinterface

// File: rtl/bcd_counter_sat.sv
// Ripple-carry BCD incrementer that holds at all-9s.
// sat flags the all-9s value.
module bcd_counter_sat
  import rt_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*N_DIGITS-1:0] q,
  output logic                  sat
);

  logic [4*N_DIGITS-1:0] q_q;
  logic [4*N_DIGITS-1:0] q_d;
  logic                  all9;
  logic                  carry;

  always_comb begin
    all9 = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (q_q[4*i +: 4] != 4'd9) all9 = 1'b0;
    end
  end

  always_comb begin
    q_d   = q_q;
    carry = inc & ~all9;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (q_q[4*i +: 4] == 4'd9) begin
          q_d[4*i +: 4] = 4'd0;
        end else begin
          q_d[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    if (clr) q_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q   = q_q;
  assign sat = all9;

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-timer engine: random arming delay, false-start
// detection, saturating BCD ms count and best-score tracking.
module reaction_timer_core
  import rt_pkg::*;
#(
  parameter int          N_DIGITS     = 4,
  parameter int          TICK_DIV     = 50000,
  parameter int          LFSR_W       = 12,
  parameter int          DELAY_MIN_MS = 1000,
  parameter int unsigned LFSR_SEED    = 32'hACE
) (
  input  logic                 CLK_50MHZ,
  input  logic                 reset_n,
  reaction_timer_core_if.slave bus
);

  localparam int W  = 4 * N_DIGITS;
  localparam int DW = LFSR_W + 1;
  localparam int PW = $clog2(TICK_DIV);

  localparam logic [LFSR_W-1:0] TAPS =
    LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [LFSR_W-1:0] SEED =
    LFSR_W'(LFSR_SEED);
  localparam logic [PW-1:0] P_LAST =
    PW'(TICK_DIV - 1);

  logic [1:0]        state_q, state_d;
  logic [DW-1:0]     delay_q, delay_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              fs_q, fs_d;
  logic              ovf_q, ovf_d;
  logic [W-1:0]      best_q, best_d;
  logic              bv_q, bv_d;
  logic              go_q, go_d;

  logic              tick;
  logic              cnt_clr, cnt_inc, cnt_sat;
  logic [W-1:0]      cnt_q;
  logic [DW-1:0]     delay_ld;

  logic is_idle, is_armed, is_run, is_done;
  logic do_clr, do_start, do_foul;
  logic do_arm, do_freeze, do_inc;

  assign tick     = (presc_q == P_LAST);
  assign delay_ld = DW'(32'(DELAY_MIN_MS) + 32'(lfsr_q));
  assign lfsr_d   = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};

  assign is_idle  = (state_q == IDLE);
  assign is_armed = (state_q == ARMED);
  assign is_run   = (state_q == RUN);
  assign is_done  = (state_q == DONE);

  // Mutually exclusive events, priority folded into the terms.
  assign do_clr    = bus.clear;
  assign do_start  = ~bus.clear & bus.start & (is_idle | is_done);
  assign do_foul   = ~bus.clear & is_armed & bus.stop;
  assign do_arm    = ~bus.clear & is_armed & ~bus.stop & tick;
  assign do_freeze = ~bus.clear & is_run & bus.stop;
  assign do_inc    = ~bus.clear & is_run & ~bus.stop & tick;

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    fs_d    = fs_q;
    ovf_d   = ovf_q;
    best_d  = best_q;
    bv_d    = bv_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (1'b1)
      do_clr: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
        ovf_d   = 1'b0;
        fs_d    = 1'b0;
      end
      do_start: begin
        state_d = ARMED;
        delay_d = delay_ld;
        cnt_clr = 1'b1;
        ovf_d   = 1'b0;
        fs_d    = 1'b0;
        presc_d = '0;
      end
      do_foul: begin
        state_d = IDLE;
        fs_d    = 1'b1;
      end
      do_arm: begin
        if (delay_q == '0) begin
          state_d = RUN;
          cnt_clr = 1'b1;
        end else begin
          delay_d = delay_q - 1'b1;
        end
      end
      do_freeze: begin
        state_d = DONE;
        if (!ovf_q && (!bv_q || cnt_q < best_q)) begin
          best_d = cnt_q;
          bv_d   = 1'b1;
        end
      end
      do_inc: begin
        cnt_inc = 1'b1;
        if (cnt_sat) ovf_d = 1'b1;
      end
      default: ;
    endcase
    if (bus.best_clr) begin
      best_d = '0;
      bv_d   = 1'b0;
    end
    go_d = (state_d == RUN);
  end

  always_ff @(posedge CLK_50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      delay_q <= '0;
      presc_q <= '0;
      lfsr_q  <= SEED;
      fs_q    <= 1'b0;
      ovf_q   <= 1'b0;
      best_q  <= '0;
      bv_q    <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      presc_q <= presc_d;
      lfsr_q  <= lfsr_d;
      fs_q    <= fs_d;
      ovf_q   <= ovf_d;
      best_q  <= best_d;
      bv_q    <= bv_d;
      go_q    <= go_d;
    end
  end

  bcd_counter_sat #(
    .N_DIGITS (N_DIGITS)
  ) u_cnt (
    .clk   (CLK_50MHZ),
    .rst_n (reset_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .q     (cnt_q),
    .sat   (cnt_sat)
  );

  assign bus.state       = state_q;
  assign bus.go_led      = go_q;
  assign bus.false_start = fs_q;
  assign bus.count_bcd   = cnt_q;
  assign bus.best_bcd    = best_q;
  assign bus.best_valid  = bv_q;
  assign bus.overflow    = ovf_q;
  assign bus.disp_bcd    = bus.show_best ? best_q : cnt_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core: trial vector table
// plus hand sequences for fouls, priorities, overflow, reset.
module tb_reaction_timer_core;
  import rt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reaction_timer_core_if #(.N_DIGITS(4)) bus1 ();
  reaction_timer_core_if #(.N_DIGITS(2)) bus2 ();

  reaction_timer_core #(
    .N_DIGITS(4), .TICK_DIV(4), .LFSR_W(4),
    .DELAY_MIN_MS(2), .LFSR_SEED(4'h1)
  ) u1 (
    .CLK_50MHZ(clk), .reset_n(rst_n), .bus(bus1)
  );

  reaction_timer_core #(
    .N_DIGITS(2), .TICK_DIV(4), .LFSR_W(4),
    .DELAY_MIN_MS(2), .LFSR_SEED(4'h1)
  ) u2 (
    .CLK_50MHZ(clk), .reset_n(rst_n), .bus(bus2)
  );

  // x^4+x^3+1 sequence from seed 1, one step per clock.
  logic [3:0] lseq [15] = '{
    4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
    4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8
  };
  int edges;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;

  typedef struct {
    int         ticks;
    bit         coin;
    bit         bclr;
    logic [15:0] ecnt;
    logic [15:0] ebest;
    bit         ebv;
  } vec_t;
  vec_t tv [6];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm_to_run(input string tag);
    int d, k;
    d = 2 + int'(lseq[edges % 15]);
    bus1.start = 1'b1;
    cyc();
    bus1.start = 1'b0;
    chk({tag, " armed"}, 32'(bus1.state), 32'(ARMED));
    chk({tag, " fs_clr"}, 32'(bus1.false_start), 0);
    k = 0;
    while (bus1.state != RUN && k < 300) begin
      cyc();
      k++;
    end
    chk({tag, " arm_cycles"}, k, 4 * (d + 1));
    chk({tag, " go_led"}, 32'(bus1.go_led), 1);
  endtask

  task automatic run_vec(input int i);
    string t;
    t = $sformatf("vec%0d", i);
    arm_to_run(t);
    cyc(4 * tv[i].ticks + (tv[i].coin ? 3 : 0));
    bus1.stop     = 1'b1;
    bus1.best_clr = tv[i].bclr;
    cyc();
    bus1.stop     = 1'b0;
    bus1.best_clr = 1'b0;
    chk({t, " state"}, 32'(bus1.state), 32'(DONE));
    chk({t, " count"}, 32'(bus1.count_bcd), 32'(tv[i].ecnt));
    chk({t, " best"}, 32'(bus1.best_bcd), 32'(tv[i].ebest));
    chk({t, " bvalid"}, 32'(bus1.best_valid), 32'(tv[i].ebv));
    chk({t, " go_led"}, 32'(bus1.go_led), 0);
    chk({t, " ovf"}, 32'(bus1.overflow), 0);
    chk({t, " disp"}, 32'(bus1.disp_bcd), 32'(tv[i].ecnt));
  endtask

  initial begin
    int d2, k;
    tv[0] = '{37, 1'b0, 1'b0, 16'h0037, 16'h0037, 1'b1};
    tv[1] = '{52, 1'b0, 1'b0, 16'h0052, 16'h0037, 1'b1};
    tv[2] = '{ 9, 1'b0, 1'b0, 16'h0009, 16'h0009, 1'b1};
    tv[3] = '{19, 1'b1, 1'b0, 16'h0019, 16'h0009, 1'b1};
    tv[4] = '{20, 1'b0, 1'b0, 16'h0020, 16'h0020, 1'b1};
    tv[5] = '{ 5, 1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0};

    {bus1.start, bus1.stop, bus1.clear} = '0;
    {bus1.best_clr, bus1.show_best} = '0;
    {bus2.start, bus2.stop, bus2.clear} = '0;
    {bus2.best_clr, bus2.show_best} = '0;

    cyc(2);
    chk("rst state", 32'(bus1.state), 32'(IDLE));
    chk("rst count", 32'(bus1.count_bcd), 0);
    chk("rst best", 32'(bus1.best_bcd), 0);
    chk("rst bvalid", 32'(bus1.best_valid), 0);
    chk("rst go", 32'(bus1.go_led), 0);
    chk("rst fs", 32'(bus1.false_start), 0);
    chk("rst ovf", 32'(bus1.overflow), 0);
    rst_n = 1'b1;
    cyc(3);

    for (int i = 0; i < 4; i++) begin
      run_vec(i);
      if (i == 2) begin
        bus1.show_best = 1'b1;
        #1;
        chk("show_best disp", 32'(bus1.disp_bcd), 32'h0009);
        bus1.show_best = 1'b0;
      end
    end

    // False start one tick after start.
    bus1.start = 1'b1;
    cyc();
    bus1.start = 1'b0;
    cyc(3);
    bus1.stop = 1'b1;
    cyc();
    bus1.stop = 1'b0;
    chk("foul state", 32'(bus1.state), 32'(IDLE));
    chk("foul fs", 32'(bus1.false_start), 1);
    chk("foul count", 32'(bus1.count_bcd), 0);
    chk("foul best", 32'(bus1.best_bcd), 32'h0009);
    chk("foul bvalid", 32'(bus1.best_valid), 1);
    bus1.start = 1'b1;
    cyc();
    bus1.start = 1'b0;
    chk("restart state", 32'(bus1.state), 32'(ARMED));
    chk("restart fs", 32'(bus1.false_start), 0);
    bus1.clear = 1'b1;
    cyc();
    bus1.clear = 1'b0;
    chk("clear armed", 32'(bus1.state), 32'(IDLE));

    bus1.clear = 1'b1;
    bus1.start = 1'b1;
    cyc();
    bus1.clear = 1'b0;
    bus1.start = 1'b0;
    chk("clear+start", 32'(bus1.state), 32'(IDLE));
    chk("clear+start best", 32'(bus1.best_bcd), 32'h0009);

    // Two-digit overflow on the second core.
    d2 = 2 + int'(lseq[edges % 15]);
    bus2.start = 1'b1;
    cyc();
    bus2.start = 1'b0;
    k = 0;
    while (bus2.state != RUN && k < 300) begin
      cyc();
      k++;
    end
    chk("n2 arm_cycles", k, 4 * (d2 + 1));
    cyc(4 * 120);
    chk("n2 count", 32'(bus2.count_bcd), 32'h99);
    chk("n2 ovf", 32'(bus2.overflow), 1);
    bus2.stop = 1'b1;
    cyc();
    bus2.stop = 1'b0;
    chk("n2 state", 32'(bus2.state), 32'(DONE));
    chk("n2 frozen", 32'(bus2.count_bcd), 32'h99);
    chk("n2 bvalid", 32'(bus2.best_valid), 0);
    chk("n2 best", 32'(bus2.best_bcd), 0);

    // Asynchronous reset in the middle of RUN.
    arm_to_run("mid");
    cyc(4 * 12);
    chk("mid count", 32'(bus1.count_bcd), 32'h0012);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst state", 32'(bus1.state), 32'(IDLE));
    chk("arst count", 32'(bus1.count_bcd), 0);
    chk("arst best", 32'(bus1.best_bcd), 0);
    chk("arst bvalid", 32'(bus1.best_valid), 0);
    chk("arst go", 32'(bus1.go_led), 0);
    chk("arst ovf", 32'(bus1.overflow), 0);
    chk("arst fs", 32'(bus1.false_start), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    run_vec(4);
    run_vec(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
